jtag_scan_sequencer: RTL and testbench

//  Host-side driver for the JTAG TAP. Takes scan commands on a valid/ready port and turns them into TMS/TDI bit streams.

---
 rtl/jtag_types_pkg.sv | 32 +++
 rtl/jtag_scan_sequencer_if.sv | 16 +
 rtl/jtag_tap_model.sv | 11 +
 rtl/jtag_scan_sequencer.sv | 100 ++++++++++
 tb/tb_jtag_scan_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg: TAP state and scan-command types, plus the IEEE 1149.1 TAP transition function
package jtag_types_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } state_t;
  typedef enum logic [1:0] {OP_RESET, OP_IDLE, OP_IR, OP_DR} seq_op_t;
  typedef enum logic [2:0] {S_INIT, S_READY, S_WALK, S_SHIFT, S_EXIT, S_RUN, S_RESP} seq_state_t;
  localparam int INIT_TMS_ONES = 5;
  function automatic state_t tap_next(state_t s, logic tms);
    case (s)
      TEST_LOGIC_RESET: return tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return tms ? SELECT_IR_SCAN : CAPTURE_DR;
      CAPTURE_DR:       return tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         return tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         return tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         return tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         return tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        return tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   return tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         return tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         return tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        return tms ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      default:          return TEST_LOGIC_RESET;
    endcase
  endfunction
endpackage

// File: rtl/jtag_scan_sequencer_if.sv
// jtag_scan_sequencer_if: command/response handshake ports of the scan sequencer
interface jtag_scan_sequencer_if
  import jtag_types_pkg::*;
#(parameter int MAX_LEN = 32);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic cmd_valid, cmd_ready;
  seq_op_t cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [MAX_LEN-1:0] rsp_data;
  modport master (output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
                  input cmd_ready, rsp_valid, rsp_data, rsp_err);
  modport slave (input cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
                 output cmd_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/jtag_tap_model.sv
// jtag_tap_model: cycle-exact registered mirror of the TAP controller state
module jtag_tap_model
  import jtag_types_pkg::*;
(
  input  logic   TCK,
  input  logic   TRST,
  input  logic   tms,
  output state_t tap_state
);
  always_ff @(posedge TCK) tap_state <= TRST ? TEST_LOGIC_RESET : tap_next(tap_state, tms);
endmodule

// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: turns scan commands into TMS/TDI streams and returns captured TDO.
// JTAG_SEQ_TDO_CAPTURE_EN enables TDO capture into rsp_data; otherwise rsp_data is 0.
module jtag_scan_sequencer
  import jtag_types_pkg::*;
#(parameter int MAX_LEN = 32)
(
  input  logic   TCK,
  input  logic   TRST,
  jtag_scan_sequencer_if.slave bus,
  output logic   tms,
  output logic   tdi,
  input  logic   tdo,
  output state_t tap_state,
  output logic   busy
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = LEN_W > 3 ? LEN_W : 3;
  seq_state_t state, nxt;
  seq_op_t op;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] idx, len;
  logic [MAX_LEN-1:0] data;
  logic err, cmd_init, fire, last, bad_len, is_ir;
  jtag_tap_model u_tap (.TCK(TCK), .TRST(TRST), .tms(tms), .tap_state(tap_state));
  assign fire = bus.cmd_valid && bus.cmd_ready;
  assign is_ir = op == OP_IR;
  assign last = idx == len - 1'b1;
  assign bad_len = bus.cmd_len == '0 || bus.cmd_len > LEN_W'(MAX_LEN);
  assign busy = state != S_READY;
  assign bus.cmd_ready = state == S_READY && tap_state == RUN_TEST_IDLE;
  assign bus.rsp_valid = state == S_RESP;
  assign bus.rsp_err = err;
  // WALK/EXIT steer TMS from the mirrored TAP state rather than a step counter
  always_comb begin
    nxt = state;
    tms = 1'b0;
    tdi = 1'b0;
    case (state)
      S_INIT: begin
        tms = cnt < CNT_W'(INIT_TMS_ONES);
        if (cnt == CNT_W'(INIT_TMS_ONES)) nxt = cmd_init ? S_RESP : S_READY;
      end
      S_READY: if (fire) nxt = bus.cmd_op == OP_RESET ? S_INIT :
                               bus.cmd_op == OP_IDLE ? (bus.cmd_len == '0 ? S_RESP : S_RUN) :
                               bad_len ? S_RESP : S_WALK;
      S_WALK: begin
        tms = tap_state == RUN_TEST_IDLE || (is_ir && tap_state == SELECT_DR_SCAN);
        if (tap_state inside {CAPTURE_DR, CAPTURE_IR}) nxt = S_SHIFT;
      end
      S_SHIFT: begin
        tms = last;
        tdi = data[0];
        if (last) nxt = S_EXIT;
      end
      S_EXIT: begin
        tms = tap_state inside {EXIT1_DR, EXIT1_IR};
        if (tap_state inside {UPDATE_DR, UPDATE_IR}) nxt = S_RESP;
      end
      S_RUN: if (cnt == CNT_W'(len) - 1'b1) nxt = S_RESP;
      S_RESP: if (bus.rsp_ready) nxt = S_READY;
      default: nxt = S_INIT;
    endcase
  end
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state <= S_INIT;
      cnt <= '0;
      idx <= '0;
      op <= OP_RESET;
      len <= '0;
      data <= '0;
      err <= 1'b0;
      cmd_init <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      idx <= state == S_SHIFT ? idx + 1'b1 : '0;
      data <= state == S_SHIFT ? data >> 1 : data;
      if (fire) begin
        op <= bus.cmd_op;
        len <= bus.cmd_len;
        data <= bus.cmd_data;
        cmd_init <= bus.cmd_op == OP_RESET;
        err <= bus.cmd_op inside {OP_IR, OP_DR} && bad_len;
      end
    end
  end
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
  logic [MAX_LEN-1:0] cap;
  always_ff @(posedge TCK) begin
    if (TRST || fire) cap <= '0;
    else if (state == S_SHIFT) cap <= cap | (MAX_LEN'(tdo) << idx);
  end
  assign bus.rsp_data = cap;
`else
  logic unused_tdo;
  assign unused_tdo = tdo;
  assign bus.rsp_data = '0;
`endif
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: sequencer driving an independent TAP controller model on shared TCK/TMS
module tb_jtag_scan_sequencer;
  import jtag_types_pkg::*;
  localparam int MAX_LEN = 32;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic TCK = 1'b0, TRST = 1'b1;
  logic tms, tdi, tdo, busy;
  state_t tap_state;
  state_t tb_tap = SHIFT_IR;
  logic tdo_q = 1'b0, loop_en = 1'b0, rnd_tdo = 1'b0;
  state_t tbl [16][2];
  int n_chk = 0, n_fail = 0;
  jtag_scan_sequencer_if #(.MAX_LEN(MAX_LEN)) bus ();
  jtag_scan_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .TCK(TCK), .TRST(TRST), .bus(bus), .tms(tms), .tdi(tdi), .tdo(tdo),
    .tap_state(tap_state), .busy(busy)
  );
  always #5 TCK = ~TCK;
  assign tdo = loop_en ? tdo_q : rnd_tdo;
  always @(posedge TCK) begin
    tb_tap <= tbl[tb_tap][tms === 1'b1 ? 1 : 0];
    tdo_q <= tdi;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic init_seq();
    for (int k = 0; k < 6; k++) begin
      chk("init_tms", tms, k < 5);
      chk("init_rdy", bus.cmd_ready, 0);
      chk("init_rsp", bus.rsp_valid, 0);
      if (k == 5) chk("init_tlr", tb_tap, TEST_LOGIC_RESET);
      @(negedge TCK);
    end
    chk("init_cmd_ready", bus.cmd_ready, 1);
    chk("init_mirror_rti", tap_state, RUN_TEST_IDLE);
    chk("init_tap_rti", tb_tap, RUN_TEST_IDLE);
    chk("init_busy", busy, 0);
    chk("init_no_rsp", bus.rsp_valid, 0);
  endtask
  task automatic do_cmd(input seq_op_t op, input int len, input logic [31:0] d, input bit loop, input int hold);
    bit q[$];
    bit exp_err, scan, shifting;
    int i, n_upd;
    logic [63:0] rec, want, mask;
    exp_err = (op == OP_IR || op == OP_DR) && (len < 1 || len > MAX_LEN);
    scan = (op == OP_IR || op == OP_DR) && !exp_err;
    mask = (64'd1 << len) - 64'd1;
    if (op == OP_RESET) q = '{1, 1, 1, 1, 1, 0};
    else if (op == OP_IDLE) repeat (len) q.push_back(1'b0);
    else if (scan) begin
      if (op == OP_IR) q = '{1, 1, 0, 0};
      else q = '{1, 0, 0};
      repeat (len - 1) q.push_back(1'b0);
      q.push_back(1'b1);
      q.push_back(1'b1);
      q.push_back(1'b0);
    end
    chk("pre_cmd_ready", bus.cmd_ready, 1);
    loop_en = loop;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_len = LEN_W'(len);
    bus.cmd_data = d;
    @(negedge TCK);
    bus.cmd_valid = 1'b0;
    bus.cmd_data = $urandom;
    i = 0;
    n_upd = 0;
    rec = '0;
    foreach (q[k]) begin
      rnd_tdo = 1'($urandom_range(0, 1));
      shifting = tb_tap == SHIFT_IR || tb_tap == SHIFT_DR;
      chk("seq_tms", tms, q[k]);
      chk("seq_tdi", tdi, shifting ? d[i] : 1'b0);
      chk("seq_no_rsp", bus.rsp_valid, 0);
      chk("seq_busy", busy, 1);
      if (shifting) begin
        rec |= 64'(rnd_tdo) << i;
        i++;
      end
      if (tb_tap == UPDATE_IR) n_upd++;
      @(negedge TCK);
    end
    want = '0;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
    if (scan) want = loop ? ({32'b0, d} << 1) & mask : rec;
`endif
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_data", bus.rsp_data, want);
    chk("rsp_tms0", tms, 0);
    chk("rsp_mirror_rti", tap_state, RUN_TEST_IDLE);
    chk("rsp_tap_rti", tb_tap, RUN_TEST_IDLE);
    chk("shift_count", i, scan ? len : 0);
    chk("ir_update_cycles", n_upd, (scan && op == OP_IR) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_RESET;
      @(negedge TCK);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      chk("hold_tms", tms, 0);
      chk("hold_data", bus.rsp_data, want);
      chk("hold_tap", tb_tap, RUN_TEST_IDLE);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge TCK);
    bus.rsp_ready = 1'b0;
    chk("rsp_cleared", bus.rsp_valid, 0);
    chk("ready_after_rsp", bus.cmd_ready, 1);
  endtask
  initial begin
    int k, sh;
    tbl[TEST_LOGIC_RESET] = '{RUN_TEST_IDLE, TEST_LOGIC_RESET};
    tbl[RUN_TEST_IDLE]    = '{RUN_TEST_IDLE, SELECT_DR_SCAN};
    tbl[SELECT_DR_SCAN]   = '{CAPTURE_DR, SELECT_IR_SCAN};
    tbl[CAPTURE_DR]       = '{SHIFT_DR, EXIT1_DR};
    tbl[SHIFT_DR]         = '{SHIFT_DR, EXIT1_DR};
    tbl[EXIT1_DR]         = '{PAUSE_DR, UPDATE_DR};
    tbl[PAUSE_DR]         = '{PAUSE_DR, EXIT2_DR};
    tbl[EXIT2_DR]         = '{SHIFT_DR, UPDATE_DR};
    tbl[UPDATE_DR]        = '{RUN_TEST_IDLE, SELECT_DR_SCAN};
    tbl[SELECT_IR_SCAN]   = '{CAPTURE_IR, TEST_LOGIC_RESET};
    tbl[CAPTURE_IR]       = '{SHIFT_IR, EXIT1_IR};
    tbl[SHIFT_IR]         = '{SHIFT_IR, EXIT1_IR};
    tbl[EXIT1_IR]         = '{PAUSE_IR, UPDATE_IR};
    tbl[PAUSE_IR]         = '{PAUSE_IR, EXIT2_IR};
    tbl[EXIT2_IR]         = '{SHIFT_IR, UPDATE_IR};
    tbl[UPDATE_IR]        = '{RUN_TEST_IDLE, SELECT_DR_SCAN};
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_IDLE;
    bus.cmd_len = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    @(negedge TCK);
    chk("rst_state", tap_state, TEST_LOGIC_RESET);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", busy, 1);
    @(negedge TCK);
    TRST = 1'b0;
    init_seq();
    do_cmd(OP_IR, 4, 32'b1010, 1'b0, 0);
    do_cmd(OP_DR, 8, 32'hA5, 1'b1, 0);
    do_cmd(OP_DR, 0, 32'hFFFF_FFFF, 1'b0, 0);
    do_cmd(OP_DR, MAX_LEN + 1, 32'hFFFF_FFFF, 1'b0, 0);
    do_cmd(OP_IR, 0, 32'h1234, 1'b0, 1);
    do_cmd(OP_IR, (1 << LEN_W) - 1, 32'h1234, 1'b0, 0);
    do_cmd(OP_IDLE, 3, 32'h0, 1'b0, 20);
    do_cmd(OP_IDLE, 0, 32'h0, 1'b0, 2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_DR;
    bus.cmd_len = LEN_W'(16);
    bus.cmd_data = $urandom;
    @(negedge TCK);
    bus.cmd_valid = 1'b0;
    k = 0;
    sh = 0;
    while (k < 40 && !(tb_tap == SHIFT_DR && sh == 3)) begin
      if (tb_tap == SHIFT_DR) sh++;
      @(negedge TCK);
      k++;
    end
    chk("trst_reached_bit3", k < 40, 1);
    TRST = 1'b1;
    @(negedge TCK);
    chk("trst_no_rsp", bus.rsp_valid, 0);
    chk("trst_mirror", tap_state, TEST_LOGIC_RESET);
    chk("trst_busy", busy, 1);
    chk("trst_tms", tms, 1);
    TRST = 1'b0;
    init_seq();
    do_cmd(OP_RESET, $urandom_range(0, 40), 32'h0, 1'b0, 1);
    do_cmd(OP_DR, MAX_LEN, $urandom, 1'b0, 0);
    do_cmd(OP_IR, MAX_LEN, $urandom, 1'b1, 0);
    do_cmd(OP_DR, 1, 32'h1, 1'b0, 0);
    do_cmd(OP_IR, 1, 32'h0, 1'b1, 0);
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: do_cmd(OP_IDLE, $urandom_range(0, 6), $urandom, 1'b0, $urandom_range(0, 3));
        1: do_cmd(OP_IR, $urandom_range(1, MAX_LEN), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        default: do_cmd(OP_DR, $urandom_range(0, MAX_LEN + 1), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      endcase
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
